bram_sp_clk_dpw: RTL and testbench
==================================

// Module: bram_sp_clk_dpw
// PURPOSE
//   Single-clock true dual-port RAM with asymmetric port widths: wide port A, narrow port B.
//   Port B reads and writes one lane of an A word, so B stores only part of the word.
//   Successor to the dual-clock mixed-width BRAM. Adds narrow-port writes, enables, read-valid
//   strobes, defined collision handling, same-port write mode and an optional output register.
//   Used as a width-converting buffer between wide datapath logic and narrow control/readout logic.
// PARAMETERS
//   A_DATA_WIDTH  32  port A word width; must equal B_DATA_WIDTH*2^k, k>=1
//   A_ADDR_WIDTH  4   port A address width; memory depth = 2**A_ADDR_WIDTH words
//   B_DATA_WIDTH  8   port B lane width
//   WRITE_FIRST   1   same-port read-during-write: 1 = data_out shows new data; 0 = old data
//   (derived) RATIO = A_DATA_WIDTH/B_DATA_WIDTH; LOG2R = log2(RATIO); B_ADDR_WIDTH = A_ADDR_WIDTH+LOG2R
// PORTS
//   clk         in   1             clock, all logic on rising edge
//   rst_n       in   1             asynchronous reset, active low
//   a_en        in   1             port A access enable
//   a_wr        in   1             port A write (qualified by a_en)
//   a_addr      in   A_ADDR_WIDTH  port A word address
//   a_data_in   in   A_DATA_WIDTH  port A write data
//   a_data_out  out  A_DATA_WIDTH  port A read data
//   a_valid     out  1             a_data_out valid strobe
//   b_en        in   1             port B access enable
//   b_wr        in   1             port B write (qualified by b_en)
//   b_addr      in   B_ADDR_WIDTH  port B lane address
//   b_data_in   in   B_DATA_WIDTH  port B write data
//   b_data_out  out  B_DATA_WIDTH  port B read data
//   b_valid     out  1             b_data_out valid strobe
//   collision   out  1             pulse: both ports wrote the same word in one cycle
// BEHAVIOUR
//   - Mapping: word = b_addr[B_ADDR_WIDTH-1:LOG2R]; lane = b_addr[LOG2R-1:0].
//     Lane n occupies word bits [(n+1)*B_DATA_WIDTH-1 : n*B_DATA_WIDTH]; lane 0 is the LSBs.
//   - Reset (rst_n=0, async): a_data_out, b_data_out, a_valid, b_valid and collision go to 0 at once.
//     Memory contents are not reset.
//   - Reset released mid-operation: accesses presented during reset are discarded.
//     First valid strobe comes 1 cycle (2 with OUTREG) after the first enabled access after release.
//   - Latency: an access in cycle N drives data_out and asserts valid=1 in cycle N+1.
//     valid is 0 in any cycle following a cycle with en=0; data_out holds its last value.
//   - Write: a_en&a_wr writes the whole word. b_en&b_wr writes only the addressed lane.
//     Other lanes of that word are unchanged.
//   - Writes also produce a read strobe. data_out follows WRITE_FIRST (1: new data, 0: prior contents).
//   - Cross-port read of a word written by the other port in the same cycle returns the old contents.
//     The new value is visible from the next cycle.
//   - Write/write collision: a_wr and b_wr both enabled, a_addr == B word address.
//     Port A wins the whole word; port B write is dropped; collision=1 for one cycle at N+1.
//     Port B still gets its read strobe and reads its lane per WRITE_FIRST applied to port A's data.
//   - Write to different words in the same cycle: both take effect.
//   - Address wrap: addresses are full-range and never out of bounds.
// CONFIGURATION
//   BRAM_DPW_OUTREG_EN defined: extra output register stage on both ports.
//     Read latency becomes 2; valid and collision are delayed identically.
//     Both stages reset to 0.
//   Not defined: latency 1 as above, no extra stage.
// TESTING (defaults: A 32b x16, B 8b x64, WRITE_FIRST=1, macro off)
//   1. A writes 0xDDCCBBAA @3; B reads @12..15 -> b_data_out AA,BB,CC,DD, one per cycle, b_valid=1.
//   2. B writes 0x11 @13 onto word 0xDDCCBBAA; A reads @3 next cycle -> 0xDDCC11AA.
//   3. Same cycle, A writes 0x12345678 @5, B writes 0xFF @20 -> collision=1 one cycle; A read @5 -> 0x12345678.
//   4. WRITE_FIRST=0: A writes 0xCAFEF00D over 0x0 @7 -> a_data_out=0x0; next read @7 -> 0xCAFEF00D.
//   5. Drop rst_n mid-burst of B reads -> outputs 0 immediately; after release, b_valid returns 1 cycle
//      after the first b_en.
//   6. Macro on: repeat scenario 1 -> identical data, each result 2 cycles after its address.

Source files
------------

// File: rtl/bram_sp_clk_dpw.sv
// bram_sp_clk_dpw: single-clock true dual-port RAM, wide word port A and narrow lane port B (BRAM_DPW_OUTREG_EN adds an output stage).
// Read latency 1 cycle (2 with BRAM_DPW_OUTREG_EN); there is no backpressure, and every enabled access returns a valid strobe.
module bram_sp_clk_dpw #(
  parameter int A_DATA_WIDTH = 32,
  parameter int A_ADDR_WIDTH = 4,
  parameter int B_DATA_WIDTH = 8,
  parameter int WRITE_FIRST  = 1,
  localparam int RATIO        = A_DATA_WIDTH / B_DATA_WIDTH,
  localparam int LOG2R        = $clog2(RATIO),
  localparam int B_ADDR_WIDTH = A_ADDR_WIDTH + LOG2R
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_en,
  input  logic                    a_wr,
  input  logic [A_ADDR_WIDTH-1:0] a_addr,
  input  logic [A_DATA_WIDTH-1:0] a_data_in,
  output logic [A_DATA_WIDTH-1:0] a_data_out,
  output logic                    a_valid,
  input  logic                    b_en,
  input  logic                    b_wr,
  input  logic [B_ADDR_WIDTH-1:0] b_addr,
  input  logic [B_DATA_WIDTH-1:0] b_data_in,
  output logic [B_DATA_WIDTH-1:0] b_data_out,
  output logic                    b_valid,
  output logic                    collision
);
  localparam int DEPTH = 1 << A_ADDR_WIDTH;

  logic [A_DATA_WIDTH-1:0] mem [DEPTH];

  logic [A_ADDR_WIDTH-1:0] b_word;
  logic [LOG2R-1:0]        b_lane;
  logic                    a_we, b_req_we, b_we, coll;
  logic [A_DATA_WIDTH-1:0] a_old, b_old_word, b_merged, a_rd;
  logic [B_DATA_WIDTH-1:0] b_old_lane, a_lane_new, b_rd;

  logic [A_DATA_WIDTH-1:0] a_data_d, a_data_q;
  logic [B_DATA_WIDTH-1:0] b_data_d, b_data_q;
  logic                    a_vld_d, a_vld_q, b_vld_d, b_vld_q, coll_d, coll_q;

  assign b_word = b_addr[B_ADDR_WIDTH-1:LOG2R];
  assign b_lane = b_addr[LOG2R-1:0];

  always_comb begin
    // Writes are blocked while reset is held so accesses during reset leave no trace.
    a_we       = rst_n & a_en & a_wr;
    b_req_we   = rst_n & b_en & b_wr;
    coll       = a_we & b_req_we & (a_addr == b_word);
    b_we       = b_req_we & ~coll;
    a_old      = mem[a_addr];
    b_old_word = mem[b_word];
    b_old_lane = '0;
    a_lane_new = '0;
    b_merged   = b_old_word;
    for (int n = 0; n < RATIO; n++) begin
      if (b_lane == LOG2R'(n)) begin
        b_old_lane = b_old_word[n*B_DATA_WIDTH +: B_DATA_WIDTH];
        a_lane_new = a_data_in[n*B_DATA_WIDTH +: B_DATA_WIDTH];
        b_merged[n*B_DATA_WIDTH +: B_DATA_WIDTH] = b_data_in;
      end
    end
    a_rd = (a_we && WRITE_FIRST != 0) ? a_data_in : a_old;
    // On a collision port B sees port A's winning word, not its own dropped write.
    b_rd = b_old_lane;
    if (WRITE_FIRST != 0) begin
      if (coll) begin
        b_rd = a_lane_new;
      end else if (b_we) begin
        b_rd = b_data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[a_addr] <= a_data_in;
    end
    if (b_we) begin
      mem[b_word] <= b_merged;
    end
  end

  always_comb begin
    a_data_d = a_en ? a_rd : a_data_q;
    b_data_d = b_en ? b_rd : b_data_q;
    a_vld_d  = a_en;
    b_vld_d  = b_en;
    coll_d   = coll;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q <= '0;
      b_data_q <= '0;
      a_vld_q  <= 1'b0;
      b_vld_q  <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      a_data_q <= a_data_d;
      b_data_q <= b_data_d;
      a_vld_q  <= a_vld_d;
      b_vld_q  <= b_vld_d;
      coll_q   <= coll_d;
    end
  end

`ifdef BRAM_DPW_OUTREG_EN
  logic [A_DATA_WIDTH-1:0] a_data_r2_d, a_data_r2_q;
  logic [B_DATA_WIDTH-1:0] b_data_r2_d, b_data_r2_q;
  logic                    a_vld_r2_d, a_vld_r2_q, b_vld_r2_d, b_vld_r2_q, coll_r2_d, coll_r2_q;

  always_comb begin
    a_data_r2_d = a_data_q;
    b_data_r2_d = b_data_q;
    a_vld_r2_d  = a_vld_q;
    b_vld_r2_d  = b_vld_q;
    coll_r2_d   = coll_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_data_r2_q <= '0;
      b_data_r2_q <= '0;
      a_vld_r2_q  <= 1'b0;
      b_vld_r2_q  <= 1'b0;
      coll_r2_q   <= 1'b0;
    end else begin
      a_data_r2_q <= a_data_r2_d;
      b_data_r2_q <= b_data_r2_d;
      a_vld_r2_q  <= a_vld_r2_d;
      b_vld_r2_q  <= b_vld_r2_d;
      coll_r2_q   <= coll_r2_d;
    end
  end

  assign a_data_out = a_data_r2_q;
  assign b_data_out = b_data_r2_q;
  assign a_valid    = a_vld_r2_q;
  assign b_valid    = b_vld_r2_q;
  assign collision  = coll_r2_q;
`else
  assign a_data_out = a_data_q;
  assign b_data_out = b_data_q;
  assign a_valid    = a_vld_q;
  assign b_valid    = b_vld_q;
  assign collision  = coll_q;
`endif
endmodule

// File: tb/tb_bram_sp_clk_dpw.sv
// Self-checking bench for bram_sp_clk_dpw: scoreboard on the WRITE_FIRST=1 instance, direct checks on a WRITE_FIRST=0 instance.
module tb_bram_sp_clk_dpw;
`ifdef BRAM_DPW_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int WF = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_en = 0, a_wr = 0, b_en = 0, b_wr = 0;
  logic [3:0]  a_addr = '0;
  logic [31:0] a_data_in = '0, a_data_out;
  logic [5:0]  b_addr = '0;
  logic [7:0]  b_data_in = '0, b_data_out;
  logic        a_valid, b_valid, collision;

  logic        w_a_en = 0, w_a_wr = 0, w_b_en = 0, w_b_wr = 0;
  logic [3:0]  w_a_addr = '0;
  logic [31:0] w_a_data_in = '0, w_a_data_out;
  logic [5:0]  w_b_addr = '0;
  logic [7:0]  w_b_data_in = '0, w_b_data_out;
  logic        w_a_valid, w_b_valid, w_collision;

  bram_sp_clk_dpw #(.A_DATA_WIDTH(32), .A_ADDR_WIDTH(4), .B_DATA_WIDTH(8), .WRITE_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_en(a_en), .a_wr(a_wr), .a_addr(a_addr), .a_data_in(a_data_in),
    .a_data_out(a_data_out), .a_valid(a_valid),
    .b_en(b_en), .b_wr(b_wr), .b_addr(b_addr), .b_data_in(b_data_in),
    .b_data_out(b_data_out), .b_valid(b_valid), .collision(collision));

  bram_sp_clk_dpw #(.A_DATA_WIDTH(32), .A_ADDR_WIDTH(4), .B_DATA_WIDTH(8), .WRITE_FIRST(0)) dut_wf0 (
    .clk(clk), .rst_n(rst_n),
    .a_en(w_a_en), .a_wr(w_a_wr), .a_addr(w_a_addr), .a_data_in(w_a_data_in),
    .a_data_out(w_a_data_out), .a_valid(w_a_valid),
    .b_en(w_b_en), .b_wr(w_b_wr), .b_addr(w_b_addr), .b_data_in(w_b_data_in),
    .b_data_out(w_b_data_out), .b_valid(w_b_valid), .collision(w_collision));

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  int          qc[$];
  logic [31:0] mdl [16];
  logic [31:0] last_a = '0;
  logic [7:0]  last_b = '0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // Advance one cycle and check the WRITE_FIRST=1 instance against the scoreboard.
  task automatic tick();
    exp_t e;
    logic ev, ec;
    @(posedge clk);
    #1;
    cyc++;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    n_cmp++;
    if (a_valid !== ev) begin
      n_err++;
      $display("FAIL a_valid cyc=%0d got=%b want=%b", cyc, a_valid, ev);
    end
    if (ev) begin
      e = qa.pop_front();
      last_a = e.d;
    end
    n_cmp++;
    if (a_data_out !== last_a) begin
      n_err++;
      $display("FAIL a_data_out cyc=%0d got=%h want=%h", cyc, a_data_out, last_a);
    end
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    n_cmp++;
    if (b_valid !== ev) begin
      n_err++;
      $display("FAIL b_valid cyc=%0d got=%b want=%b", cyc, b_valid, ev);
    end
    if (ev) begin
      e = qb.pop_front();
      last_b = e.d[7:0];
    end
    n_cmp++;
    if (b_data_out !== last_b) begin
      n_err++;
      $display("FAIL b_data_out cyc=%0d got=%h want=%h", cyc, b_data_out, last_b);
    end
    ec = (qc.size() > 0) && (qc[0] == cyc);
    if (ec) void'(qc.pop_front());
    n_cmp++;
    if (collision !== ec) begin
      n_err++;
      $display("FAIL collision cyc=%0d got=%b want=%b", cyc, collision, ec);
    end
  endtask

  // Drive one cycle on both ports, pushing the expected results from the reference model.
  task automatic access(input logic ae, input logic aw, input logic [3:0] aa, input logic [31:0] ad,
                        input logic be, input logic bw, input logic [5:0] ba, input logic [7:0] bd);
    exp_t        e;
    logic [3:0]  w;
    int          ln;
    logic        cl;
    logic [7:0]  bl;
    a_en = ae; a_wr = aw; a_addr = aa; a_data_in = ad;
    b_en = be; b_wr = bw; b_addr = ba; b_data_in = bd;
    if (rst_n) begin
      w  = ba[5:2];
      ln = int'(ba[1:0]);
      cl = ae && aw && be && bw && (aa == w);
      if (ae) begin
        e.d   = (aw && WF != 0) ? ad : mdl[aa];
        e.due = cyc + LAT;
        qa.push_back(e);
      end
      if (be) begin
        bl = mdl[w][ln*8 +: 8];
        if (WF != 0) begin
          if (cl) bl = ad[ln*8 +: 8];
          else if (bw) bl = bd;
        end
        e.d   = {24'h0, bl};
        e.due = cyc + LAT;
        qb.push_back(e);
      end
      if (cl) qc.push_back(cyc + LAT);
      if (ae && aw) mdl[aa] = ad;
      if (be && bw && !cl) mdl[w][ln*8 +: 8] = bd;
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) access(0, 0, 4'd0, 32'h0, 0, 0, 6'd0, 8'h0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (a_data_out !== 32'h0 || b_data_out !== 8'h0 || a_valid !== 1'b0 || b_valid !== 1'b0 || collision !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got a=%h b=%h av=%b bv=%b c=%b want all 0", a_data_out, b_data_out, a_valid, b_valid, collision);
    end
    tick();
    tick();
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_a_write_b_read();
    access(1, 1, 4'd3, 32'hDDCCBBAA, 0, 0, 6'd0, 8'h0);
    for (int i = 12; i < 16; i++) access(0, 0, 4'd0, 32'h0, 1, 0, 6'(i), 8'h0);
    idle(LAT + 1);
  endtask

  task automatic test_b_lane_write();
    access(0, 0, 4'd0, 32'h0, 1, 1, 6'd13, 8'h11);
    access(1, 0, 4'd3, 32'h0, 0, 0, 6'd0, 8'h0);
    idle(LAT + 1);
  endtask

  task automatic test_collision();
    access(1, 1, 4'd5, 32'h12345678, 1, 1, 6'd20, 8'hFF);
    access(1, 0, 4'd5, 32'h0, 1, 0, 6'd20, 8'h0);
    idle(LAT + 1);
  endtask

  task automatic test_cross_port();
    access(1, 1, 4'd8, 32'h0BADBEEF, 0, 0, 6'd0, 8'h0);
    access(1, 1, 4'd8, 32'hA5A5C3C3, 1, 0, 6'd34, 8'h0);
    access(1, 1, 4'd10, 32'h55667788, 1, 1, 6'd39, 8'h9E);
    access(1, 0, 4'd9, 32'h0, 1, 0, 6'd42, 8'h0);
    access(1, 0, 4'd8, 32'h0, 1, 0, 6'd33, 8'h0);
    access(0, 0, 4'd0, 32'h0, 1, 0, 6'd63, 8'h0);
    idle(LAT + 1);
  endtask

  task automatic test_back_to_back();
    logic [3:0] aa;
    logic [5:0] ba;
    for (int i = 0; i < 16; i++) access(1, 1, 4'(i), $urandom, 1, 0, 6'(i * 4 + 3), 8'h0);
    for (int i = 0; i < 300; i++) begin
      aa = 4'($urandom);
      ba = 6'($urandom);
      if ($urandom_range(0, 3) == 0) ba[5:2] = aa;
      access(1'($urandom), 1'($urandom), aa, $urandom, 1'($urandom), 1'($urandom), ba, 8'($urandom));
    end
    idle(LAT + 1);
  endtask

  task automatic test_wf0();
    a_en = 0; b_en = 0;
    w_a_en = 1; w_a_wr = 1; w_a_addr = 4'd7; w_a_data_in = 32'h0;
    tick();
    w_a_data_in = 32'hCAFEF00D;
    tick();
    w_a_en = 0;
    for (int i = 1; i < LAT; i++) tick();
    n_cmp++;
    if (w_a_valid !== 1'b1 || w_a_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL wf0_write_old got v=%b d=%h want v=1 d=00000000", w_a_valid, w_a_data_out);
    end
    tick();
    n_cmp++;
    if (w_a_valid !== 1'b0 || w_a_data_out !== 32'h0) begin
      n_err++;
      $display("FAIL wf0_idle_hold got v=%b d=%h want v=0 d=00000000", w_a_valid, w_a_data_out);
    end
    w_a_en = 1; w_a_wr = 0;
    w_b_en = 1; w_b_wr = 1; w_b_addr = 6'd29; w_b_data_in = 8'h77;
    tick();
    w_a_en = 0; w_b_en = 0;
    for (int i = 1; i < LAT; i++) tick();
    n_cmp++;
    if (w_a_data_out !== 32'hCAFEF00D || w_b_data_out !== 8'hF0 || w_b_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wf0_read got a=%h b=%h bv=%b want a=cafef00d b=f0 bv=1", w_a_data_out, w_b_data_out, w_b_valid);
    end
    w_a_en = 1; w_a_wr = 1; w_a_data_in = 32'h01020304;
    w_b_en = 1; w_b_wr = 1; w_b_addr = 6'd28; w_b_data_in = 8'h99;
    tick();
    w_a_en = 1; w_a_wr = 0; w_b_en = 0;
    for (int i = 1; i < LAT; i++) begin
      tick();
      w_a_en = 0;
    end
    n_cmp++;
    if (w_a_data_out !== 32'hCAFE770D || w_b_data_out !== 8'h0D || w_collision !== 1'b1) begin
      n_err++;
      $display("FAIL wf0_collision got a=%h b=%h c=%b want a=cafe770d b=0d c=1", w_a_data_out, w_b_data_out, w_collision);
    end
    tick();
    w_a_en = 0;
    for (int i = 1; i < LAT; i++) tick();
    n_cmp++;
    if (w_a_data_out !== 32'h01020304 || w_collision !== 1'b0) begin
      n_err++;
      $display("FAIL wf0_after_collision got a=%h c=%b want a=01020304 c=0", w_a_data_out, w_collision);
    end
    idle(LAT + 1);
  endtask

  task automatic test_reset_mid();
    access(1, 1, 4'd3, 32'h44332211, 0, 0, 6'd0, 8'h0);
    access(0, 0, 4'd0, 32'h0, 1, 0, 6'd12, 8'h0);
    access(0, 0, 4'd0, 32'h0, 1, 0, 6'd13, 8'h0);
    b_addr = 6'd14;
    #3 rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (a_data_out !== 32'h0 || b_data_out !== 8'h0 || a_valid !== 1'b0 || b_valid !== 1'b0 || collision !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got a=%h b=%h av=%b bv=%b c=%b want all 0", a_data_out, b_data_out, a_valid, b_valid, collision);
    end
    qa.delete(); qb.delete(); qc.delete();
    last_a = '0; last_b = '0;
    access(0, 0, 4'd0, 32'h0, 1, 1, 6'd14, 8'h5A);
    access(1, 1, 4'd3, 32'hFFFFFFFF, 1, 0, 6'd15, 8'h0);
    rst_n = 1'b1;
    idle(2);
    access(0, 0, 4'd0, 32'h0, 1, 0, 6'd14, 8'h0);
    access(0, 0, 4'd0, 32'h0, 1, 0, 6'd15, 8'h0);
    access(1, 0, 4'd3, 32'h0, 0, 0, 6'd0, 8'h0);
    idle(LAT + 1);
  endtask

  initial begin
    test_reset();
    test_a_write_b_read();
    test_b_lane_write();
    test_collision();
    test_cross_port();
    test_back_to_back();
    test_wf0();
    test_reset_mid();
    idle(LAT + 2);
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0 || qc.size() != 0) begin
      n_err++;
      $display("FAIL drain got pending a=%0d b=%0d c=%0d want 0", qa.size(), qb.size(), qc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
